// File: rtl/vec_strided_mem_unit.sv
// Strided vector load/store engine (vlse.v / vsse.v, SEW 8/16/32).
// One word-aligned memory request per element. A zero-wait memory gives 3 cycles per load element: CHK, REQ, LD_OUT.
// Each element stalls until the memory, register-read or register-write side handshakes; all outputs are registered.
//
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   cmd_*             : command handshake (base, stride, vl, sew, store); cmd_ready high only in IDLE
//   ld_valid/ready/*  : loaded element stream (zero-extended data + element index)
//   st_valid/ready/*  : store element stream from the register read path
//   mem_*             : native memory port; mem_ready is a one-cycle completion pulse
//   done, err         : end-of-command pulse; err qualifies done as an abort
module vec_strided_mem_unit #(
    parameter int VL_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_store,
    input  logic [31:0]     cmd_base,
    input  logic [31:0]     cmd_stride,
    input  logic [VL_W-1:0] cmd_vl,
    input  logic [1:0]      cmd_sew,
    output logic            ld_valid,
    input  logic            ld_ready,
    output logic [31:0]     ld_data,
    output logic [VL_W-1:0] ld_idx,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [31:0]     st_data,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [31:0]     mem_rdata,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {IDLE, CHK, ST_GET, REQ, LD_OUT, FIN} state_t;

    state_t          state;
    logic            store_q;
    logic [1:0]      sew_q;
    logic [VL_W-1:0] vl_q;
    logic [VL_W-1:0] idx_q;
    logic [31:0]     stride_q;
    logic [31:0]     addr_q;

    logic [1:0]      off;
    logic            misal;
    logic [3:0]      lane_strb;
    logic [31:0]     lane_wdata;
    logic [31:0]     rd_shift;
    logic [31:0]     ld_elem;

    assign off = addr_q[1:0];

    // Elements must be naturally aligned inside the word; sew==3 is reserved.
    assign misal = (sew_q == 2'd3)
                || ((sew_q == 2'd1) && addr_q[0])
                || ((sew_q == 2'd2) && (off != 2'b00));

    // Byte-lane steering: replicate the element across the word so the
    // strobe alone selects which copy lands in memory.
    assign rd_shift = mem_rdata >> {off, 3'b000};

    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = st_data;
        ld_elem    = mem_rdata;
        case (sew_q)
            2'd0: begin
                lane_strb  = 4'b0001 << off;
                lane_wdata = {4{st_data[7:0]}};
                ld_elem    = {24'h0, rd_shift[7:0]};
            end
            2'd1: begin
                lane_strb  = off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{st_data[15:0]}};
                ld_elem    = {16'h0, rd_shift[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            store_q   <= 1'b0;
            sew_q     <= 2'd0;
            vl_q      <= '0;
            idx_q     <= '0;
            stride_q  <= 32'h0;
            addr_q    <= 32'h0;
            cmd_ready <= 1'b1;
            ld_valid  <= 1'b0;
            ld_data   <= 32'h0;
            ld_idx    <= '0;
            st_ready  <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        store_q   <= cmd_store;
                        sew_q     <= cmd_sew;
                        vl_q      <= cmd_vl;
                        stride_q  <= cmd_stride;
                        addr_q    <= cmd_base;
                        idx_q     <= '0;
                        cmd_ready <= 1'b0;
                        state     <= CHK;
                    end
                end
                CHK: begin
                    if (idx_q == vl_q) begin
                        done  <= 1'b1;
                        err   <= 1'b0;
                        state <= FIN;
                    end else if (misal) begin
                        // Abort before touching memory; earlier elements stand.
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= FIN;
                    end else if (store_q) begin
                        st_ready <= 1'b1;
                        state    <= ST_GET;
                    end else begin
                        mem_valid <= 1'b1;
                        mem_addr  <= {addr_q[31:2], 2'b00};
                        mem_wstrb <= 4'b0000;
                        state     <= REQ;
                    end
                end
                ST_GET: begin
                    if (st_valid) begin
                        st_ready  <= 1'b0;
                        mem_valid <= 1'b1;
                        mem_addr  <= {addr_q[31:2], 2'b00};
                        mem_wstrb <= lane_strb;
                        mem_wdata <= lane_wdata;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (store_q) begin
                            addr_q <= addr_q + stride_q;
                            idx_q  <= idx_q + 1'b1;
                            state  <= CHK;
                        end else begin
                            ld_valid <= 1'b1;
                            ld_data  <= ld_elem;
                            ld_idx   <= idx_q;
                            state    <= LD_OUT;
                        end
                    end
                end
                LD_OUT: begin
                    if (ld_ready) begin
                        ld_valid <= 1'b0;
                        addr_q   <= addr_q + stride_q;
                        idx_q    <= idx_q + 1'b1;
                        state    <= CHK;
                    end
                end
                FIN: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_strided_mem_unit.sv
module tb_vec_strided_mem_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_store = 1'b0;
    logic [31:0] cmd_base = 32'h0;
    logic [31:0] cmd_stride = 32'h0;
    logic [5:0]  cmd_vl = 6'd0;
    logic [1:0]  cmd_sew = 2'd0;
    logic        ld_valid;
    logic        ld_ready = 1'b1;
    logic [31:0] ld_data;
    logic [5:0]  ld_idx;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_data = 32'h0;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    vec_strided_mem_unit #(.VL_W(6)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_vl(cmd_vl), .cmd_sew(cmd_sew),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_idx(ld_idx),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .done(done), .err(err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- memory model (word array over bytes 0..1023) ----------------
    logic [31:0] mem [0:255];
    int mem_lat = 0;
    int wait_cnt = 0;

    assign mem_ready = mem_valid && (wait_cnt >= mem_lat);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
        if (mem_valid && mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // ---------------- scoreboard queues ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        st;
    } mexp_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] d;
    } lexp_t;

    mexp_t       mem_q [$];
    lexp_t       ld_q  [$];
    logic [31:0] st_q  [$];

    // ---------------- vector table ----------------
    typedef struct packed {
        logic             store;
        logic [31:0]      base;
        logic [31:0]      stride;
        logic [5:0]       vl;
        logic [1:0]       sew;
        int               st_delay;
        int               stall_idx;
        int               stall_len;
        logic             exp_err;
        int               n;
        int               exp_cyc;
        int               exp_st_rdy;
        logic [5:0][31:0] addr;
        logic [5:0][3:0]  strb;
        logic [5:0][31:0] dat;
        logic [5:0][31:0] st;
    } vec_t;

    vec_t tbl [0:9];

    task automatic set_cmd(input int i, input logic store, input logic [31:0] base,
                           input logic [31:0] stride, input int vl, input int sew,
                           input logic e, input int n, input int cyc, input int st_delay,
                           input int st_rdy, input int stall_idx, input int stall_len);
        tbl[i] = '0;
        tbl[i].store      = store;
        tbl[i].base       = base;
        tbl[i].stride     = stride;
        tbl[i].vl         = vl[5:0];
        tbl[i].sew        = sew[1:0];
        tbl[i].exp_err    = e;
        tbl[i].n          = n;
        tbl[i].exp_cyc    = cyc;
        tbl[i].st_delay   = st_delay;
        tbl[i].exp_st_rdy = st_rdy;
        tbl[i].stall_idx  = stall_idx;
        tbl[i].stall_len  = stall_len;
    endtask

    task automatic set_el(input int i, input int k, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] st);
        tbl[i].addr[k] = a;
        tbl[i].strb[k] = s;
        tbl[i].dat[k]  = d;
        tbl[i].st[k]   = st;
    endtask

    // ---------------- load-side driver and checker ----------------
    int          stall_idx = -1;
    int          stall_len = 0;
    int          stall_cnt = 0;
    logic [31:0] hold_d;
    logic [5:0]  hold_i;

    always @(negedge clk) begin
        if (reset) begin
            ld_ready = 1'b1;
        end else if (ld_valid) begin
            if (int'(ld_idx) == stall_idx && stall_cnt < stall_len) begin
                if (stall_cnt == 0) begin
                    hold_d = ld_data;
                    hold_i = ld_idx;
                end else begin
                    chk("ld_data_hold", ld_data, hold_d);
                    chk("ld_idx_hold", {26'h0, ld_idx}, {26'h0, hold_i});
                end
                stall_cnt++;
                ld_ready = 1'b0;
            end else begin
                ld_ready = 1'b1;
                if (ld_q.size() == 0) begin
                    chk("ld_unexpected", 32'd1, 32'd0);
                end else begin
                    lexp_t le;
                    le = ld_q.pop_front();
                    chk("ld_idx", {26'h0, ld_idx}, {26'h0, le.idx});
                    chk("ld_data", ld_data, le.d);
                end
            end
        end else begin
            ld_ready = 1'b1;
        end
    end

    // ---------------- store-side driver ----------------
    int st_delay = 0;
    int st_wait = 0;
    int st_rdy_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            st_valid = 1'b0;
            st_wait  = 0;
        end else if (st_ready) begin
            st_rdy_cnt++;
            if (st_wait < st_delay) begin
                st_wait++;
                st_valid = 1'b0;
            end else begin
                st_valid = 1'b1;
                if (st_q.size() == 0) chk("st_unexpected", 32'd1, 32'd0);
                else                  st_data = st_q.pop_front();
            end
        end else begin
            st_valid = 1'b0;
            st_wait  = 0;
        end
    end

    // ---------------- memory-side checker ----------------
    logic mv_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_valid && !mv_prev && mem_q.size() == 0)
                chk("mem_unexpected", {31'h0, mem_valid}, 32'd0);
            if (mem_valid && mem_ready && mem_q.size() > 0) begin
                mexp_t me;
                me = mem_q.pop_front();
                chk("mem_addr", mem_addr, me.a);
                chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, me.s});
                if (me.st) chk("mem_wdata", mem_wdata, me.d);
            end
        end
        mv_prev = mem_valid;
    end

    // ---------------- command helpers ----------------
    task automatic send_cmd(input logic store, input logic [31:0] base, input logic [31:0] stride,
                            input logic [5:0] vl, input logic [1:0] sew);
        @(negedge clk);
        chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'd1);
        cmd_store  = store;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_vl     = vl;
        cmd_sew    = sew;
        cmd_valid  = 1'b1;
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        mexp_t me;
        lexp_t le;
        int    cyc;
        bit    got;
        v = tbl[i];
        st_delay   = v.st_delay;
        stall_idx  = v.stall_idx;
        stall_len  = v.stall_len;
        stall_cnt  = 0;
        st_rdy_cnt = 0;
        for (int k = 0; k < v.n; k++) begin
            me.a  = v.addr[k];
            me.s  = v.strb[k];
            me.d  = v.dat[k];
            me.st = v.store;
            mem_q.push_back(me);
            if (v.store) begin
                st_q.push_back(v.st[k]);
            end else begin
                le.idx = 6'(k);
                le.d   = v.dat[k];
                ld_q.push_back(le);
            end
        end
        send_cmd(v.store, v.base, v.stride, v.vl, v.sew);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            if (done) got = 1'b1;
        end
        chk($sformatf("v%0d_done_seen", i), {31'h0, got}, 32'd1);
        chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, v.exp_err});
        if (v.exp_cyc != 0) chk($sformatf("v%0d_done_cycle", i), cyc, v.exp_cyc);
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", i), {31'h0, done}, 32'd0);
        chk($sformatf("v%0d_st_ready_cycles", i), st_rdy_cnt, v.exp_st_rdy);
        chk($sformatf("v%0d_mem_left", i), mem_q.size(), 32'd0);
        chk($sformatf("v%0d_ld_left", i), ld_q.size(), 32'd0);
        chk($sformatf("v%0d_st_left", i), st_q.size(), 32'd0);
        mem_q.delete();
        ld_q.delete();
        st_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'd1);
        chk({tag, "_ld_valid"},  {31'h0, ld_valid},  32'd0);
        chk({tag, "_st_ready"},  {31'h0, st_ready},  32'd0);
        chk({tag, "_mem_valid"}, {31'h0, mem_valid}, 32'd0);
        chk({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'd0);
        chk({tag, "_done"},      {31'h0, done},      32'd0);
        chk({tag, "_err"},       {31'h0, err},       32'd0);
        chk({tag, "_mem_addr"},  mem_addr,           32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,          32'd0);
        chk({tag, "_ld_data"},   ld_data,            32'd0);
        chk({tag, "_ld_idx"},    {26'h0, ld_idx},    32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int  cyc;
        bit  seen;
        for (int w = 0; w < 256; w++) mem[w] = 32'h0;
        mem[400/4] = 32'h04030201;
        mem[404/4] = 32'h08070605;
        mem[408/4] = 32'h0c0b0a09;
        mem[420/4] = 32'h18171615;
        mem[428/4] = 32'h101f1e1d;
        mem[440/4] = 32'h0000000a;
        mem[448/4] = 32'h0000001e;

        //      i  st    base  stride        vl sew err n cyc dly strdy stall len
        set_cmd(0, 1'b0, 400,  10,           6, 0, 0,  6, 20, 0, 0, -1, 0);
        set_el(0, 0, 400, 4'h0, 32'h01, 0);
        set_el(0, 1, 408, 4'h0, 32'h0b, 0);
        set_el(0, 2, 420, 4'h0, 32'h15, 0);
        set_el(0, 3, 428, 4'h0, 32'h1f, 0);
        set_el(0, 4, 440, 4'h0, 32'h0a, 0);
        set_el(0, 5, 448, 4'h0, 32'h00, 0);
        set_cmd(1, 1'b1, 600,  10,           2, 0, 0,  2, 0,  0, 2, -1, 0);
        set_el(1, 0, 600, 4'h1, 32'h01010101, 32'h01);
        set_el(1, 1, 608, 4'h4, 32'h0b0b0b0b, 32'h0b);
        set_cmd(2, 1'b0, 408,  32'hfffffffc, 3, 2, 0,  3, 0,  0, 0, 1, 5);
        set_el(2, 0, 408, 4'h0, 32'h0c0b0a09, 0);
        set_el(2, 1, 404, 4'h0, 32'h08070605, 0);
        set_el(2, 2, 400, 4'h0, 32'h04030201, 0);
        set_cmd(3, 1'b0, 402,  4,            2, 1, 0,  2, 0,  0, 0, -1, 0);
        set_el(3, 0, 400, 4'h0, 32'h00000403, 0);
        set_el(3, 1, 404, 4'h0, 32'h00000807, 0);
        set_cmd(4, 1'b0, 400,  1,            3, 1, 1,  1, 0,  0, 0, -1, 0);
        set_el(4, 0, 400, 4'h0, 32'h00000201, 0);
        set_cmd(5, 1'b0, 401,  4,            4, 1, 1,  0, 2,  0, 0, -1, 0);
        set_cmd(6, 1'b0, 400,  4,            2, 3, 1,  0, 2,  0, 0, -1, 0);
        set_cmd(7, 1'b0, 400,  4,            0, 2, 0,  0, 2,  0, 0, -1, 0);
        set_cmd(8, 1'b1, 402,  4,            2, 1, 0,  2, 0,  3, 8, -1, 0);
        set_el(8, 0, 400, 4'hc, 32'habcdabcd, 32'h1234abcd);
        set_el(8, 1, 404, 4'hc, 32'h55665566, 32'h00005566);
        set_cmd(9, 1'b0, 400,  1,            1, 0, 0,  1, 5,  0, 0, -1, 0);
        set_el(9, 0, 400, 4'h0, 32'h01, 0);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle");

        for (int i = 0; i <= 8; i++) run_vec(i);

        // Reset while a request is stuck waiting on memory.
        mem_lat = 1000;
        mem_q.push_back('{a: 32'd400, s: 4'h0, d: 32'h0, st: 1'b0});
        send_cmd(1'b0, 32'd400, 32'd4, 6'd1, 2'd2);
        cyc = 0;
        while (!mem_valid && cyc < 20) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
        end
        chk("rst_mid_mem_valid_seen", {31'h0, mem_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        reset = 1'b0;
        mem_q.delete();
        ld_q.delete();
        mem_lat = 0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || mem_valid) seen = 1'b1;
        end
        chk("rst_mid_quiet", {31'h0, seen}, 32'd0);

        run_vec(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
